// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-style matrix encoder controllers:
// inverse FSM state encoding, round-count defaults and the round-constant
// table type used by both the forward and inverse controllers.
package keccak_pkg;

    localparam int ROUNDS_DEF = 24;
    localparam int RW_DEF     = 5;

    typedef enum logic [3:0] {
        INV_IDLE      = 4'd0,
        INV_LOAD      = 4'd1,
        INV_ADDRC     = 4'd2,
        INV_REVALUTE  = 4'd3,
        INV_PERMUTE   = 4'd4,
        INV_ROTATE    = 4'd5,
        INV_COLPARITY = 4'd6,
        INV_COUNTDOWN = 4'd7,
        INV_DONE      = 4'd8
    } inv_state_t;

    typedef logic [63:0] rc_word_t;
    typedef rc_word_t rc_table_t [ROUNDS_DEF];

endpackage

// File: rtl/keccak_round_down_counter.sv
// Loadable round down-counter. Saturates at zero so the round index can
// never wrap; zero_o tells the controller the final round has been run.
module keccak_round_down_counter #(
    parameter int            RW      = 5,
    parameter logic [RW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [RW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [RW-1:0] cnt_o,
    output logic          zero_o
);

    logic [RW-1:0] cnt_q;

    // Load wins over decrement; decrement is ignored once at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/keccak_inv_controller.sv
// Inverse-round controller for the matrix decoder. Runs, per round,
// AddRC^-1, chi^-1 (multi-cycle, handshaked on chi_done), pi^-1, rho^-1,
// theta^-1, counting rounds down from ROUNDS-1 to 0. Moore outputs.
// Optional build macro KECCAK_INV_ABORT_EN adds an abort input that
// returns the controller to Idle from any busy state without a done pulse.
module keccak_inv_controller
    import keccak_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int RW     = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
`ifdef KECCAK_INV_ABORT_EN
    input  logic          abort,
`endif
    input  logic          start,
    input  logic          chi_done,
    output logic          wr_en,
    output logic          invAddRC_en,
    output logic          invRevalute_en,
    output logic          invPermute_en,
    output logic          invRotate_en,
    output logic          invColParity_en,
    output logic [RW-1:0] round_idx,
    output logic          busy,
    output logic          done
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    inv_state_t state_q, state_d;
    logic       abort_hit;
    logic       ctr_load, ctr_dec, ctr_zero;

`ifdef KECCAK_INV_ABORT_EN
    assign abort_hit = abort && (state_q != INV_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Round index reloads on a new decode or an abort, decrements between rounds.
    assign ctr_load = ((state_q == INV_IDLE) && start) || abort_hit;
    assign ctr_dec  = (state_q == INV_COUNTDOWN) && !ctr_zero && !abort_hit;

    keccak_round_down_counter #(
        .RW      (RW),
        .RST_VAL (LAST_ROUND)
    ) u_round_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (LAST_ROUND),
        .dec_i      (ctr_dec),
        .cnt_o      (round_idx),
        .zero_o     (ctr_zero)
    );

    // State register; reset aborts any decode in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d         = state_q;
        wr_en           = 1'b0;
        invAddRC_en     = 1'b0;
        invRevalute_en  = 1'b0;
        invPermute_en   = 1'b0;
        invRotate_en    = 1'b0;
        invColParity_en = 1'b0;
        done            = 1'b0;
        busy            = (state_q != INV_IDLE);
        case (state_q)
            INV_IDLE:      if (start) state_d = INV_LOAD;
            INV_LOAD: begin
                wr_en   = 1'b1;
                state_d = INV_ADDRC;
            end
            INV_ADDRC: begin
                invAddRC_en = 1'b1;
                state_d     = INV_REVALUTE;
            end
            INV_REVALUTE: begin
                invRevalute_en = 1'b1;
                if (chi_done) state_d = INV_PERMUTE;
            end
            INV_PERMUTE: begin
                invPermute_en = 1'b1;
                state_d       = INV_ROTATE;
            end
            INV_ROTATE: begin
                invRotate_en = 1'b1;
                state_d      = INV_COLPARITY;
            end
            INV_COLPARITY: begin
                invColParity_en = 1'b1;
                state_d         = INV_COUNTDOWN;
            end
            INV_COUNTDOWN: state_d = ctr_zero ? INV_DONE : INV_ADDRC;
            INV_DONE: begin
                done    = 1'b1;
                state_d = INV_IDLE;
            end
            default:       state_d = INV_IDLE;
        endcase
        if (abort_hit) state_d = INV_IDLE;
    end

endmodule

// File: tb/tb_keccak_inv_controller.sv
// Self-checking bench for keccak_inv_controller: a cycle-level reference
// model (position within a round plus a round number) is compared against
// every DUT output on every falling edge, alongside literal latency and
// pulse-count expectations for each decode scenario.
module tb_keccak_inv_controller;

    localparam int ROUNDS = 24;
    localparam int RW     = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          chi_done = 1'b0;
    logic          abort = 1'b0;
    logic          wr_en, invAddRC_en, invRevalute_en, invPermute_en;
    logic          invRotate_en, invColParity_en, busy, done;
    logic [RW-1:0] round_idx;

    keccak_inv_controller #(.ROUNDS(ROUNDS), .RW(RW)) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef KECCAK_INV_ABORT_EN
        .abort           (abort),
`endif
        .start           (start),
        .chi_done        (chi_done),
        .wr_en           (wr_en),
        .invAddRC_en     (invAddRC_en),
        .invRevalute_en  (invRevalute_en),
        .invPermute_en   (invPermute_en),
        .invRotate_en    (invRotate_en),
        .invColParity_en (invColParity_en),
        .round_idx       (round_idx),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: m_pos -1 = load, 0..4 = the five inverse steps,
    // 5 = between rounds, 6 = completion cycle.
    bit m_busy  = 1'b0;
    int m_pos   = 0;
    int m_round = ROUNDS - 1;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy  = 1'b0;
            m_round = ROUNDS - 1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  = 1'b1;
                m_pos   = -1;
                m_round = ROUNDS - 1;
            end
        end else if (abort) begin
            m_busy  = 1'b0;
            m_round = ROUNDS - 1;
        end else if (m_pos == 1) begin
            if (chi_done) m_pos = 2;
        end else if (m_pos == 5) begin
            if (m_round == 0) m_pos = 6;
            else begin
                m_round--;
                m_pos = 0;
            end
        end else if (m_pos == 6) begin
            m_busy = 1'b0;
        end else begin
            m_pos++;
        end
    end

    function automatic logic [31:0] dut_vec();
        return {19'd0, wr_en, invAddRC_en, invRevalute_en, invPermute_en,
                invRotate_en, invColParity_en, busy, done, round_idx};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [RW-1:0] r;
        r = RW'(m_round);
        return {19'd0, m_busy && m_pos == -1, m_busy && m_pos == 0, m_busy && m_pos == 1,
                m_busy && m_pos == 2, m_busy && m_pos == 3, m_busy && m_pos == 4,
                m_busy, m_busy && m_pos == 6, r};
    endfunction

    // Per-decode statistics gathered from the DUT outputs.
    int cnt_wr, cnt_add, cnt_chi, cnt_perm, cnt_rot, cnt_col, cnt_done;
    int first_wr, first_add, first_add_round, last_col, last_col_round;
    int chi_run, max_chi_run;

    task automatic clear_stats();
        cnt_wr = 0; cnt_add = 0; cnt_chi = 0; cnt_perm = 0; cnt_rot = 0;
        cnt_col = 0; cnt_done = 0; first_wr = -1; first_add = -1;
        first_add_round = -1; last_col = -1; last_col_round = -1;
        chi_run = 0; max_chi_run = 0;
    endtask

    // Compare process: DUT against model on every falling edge.
    initial begin
        clear_stats();
        forever begin
            @(negedge clk);
            chk("outputs_vs_model", dut_vec(), model_vec());
            if (wr_en) begin
                cnt_wr++;
                if (first_wr < 0) first_wr = cyc;
            end
            if (invAddRC_en) begin
                cnt_add++;
                if (first_add < 0) begin
                    first_add       = cyc;
                    first_add_round = int'(round_idx);
                end
            end
            if (invRevalute_en) begin
                cnt_chi++;
                chi_run++;
                if (chi_run > max_chi_run) max_chi_run = chi_run;
            end else begin
                chi_run = 0;
            end
            if (invPermute_en) cnt_perm++;
            if (invRotate_en) cnt_rot++;
            if (invColParity_en) begin
                cnt_col++;
                last_col       = cyc;
                last_col_round = int'(round_idx);
            end
            if (done) cnt_done++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one decode to its done cycle; returns start cycle, done cycle and
    // the number of chi wait cycles inserted.
    task automatic decode(input bit pre, input int stall_round, input int stall_n,
                          input bit rnd, input int pulse_round,
                          output int t0, output int tdone, output int extra);
        int stalls = 0;
        int guard  = 0;
        extra = 0;
        if (!pre) begin
            start = 1'b1;
            t0    = cyc;
            step();
            start = 1'b0;
        end else begin
            t0 = cyc - 1;
        end
        while (!done && guard < 1000) begin
            chi_done = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (invRevalute_en && int'(round_idx) == stall_round && stalls < stall_n) begin
                chi_done = 1'b0;
                stalls++;
            end
            if (invRevalute_en && !chi_done) extra++;
            start = (int'(round_idx) == pulse_round && invPermute_en) ||
                    (rnd && $urandom_range(0, 3) == 0);
            step();
            guard++;
        end
        tdone = cyc;
        chk("done_reached", {31'd0, done}, 32'd1);
        start    = 1'b0;
        chi_done = 1'b0;
    endtask

    int t0, tdone, extra, np;
    bit found;

    initial begin
        // Power-on reset and idle.
        repeat (3) step();
        chk("reset_outputs", dut_vec(), 32'd23);
        rst = 1'b0;
        repeat (10) step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Mid-simulation reset pulse while idle.
        rst = 1'b1;
        #1;
        chk("rst_pulse_outputs", dut_vec(), 32'd23);
        step();
        rst = 1'b0;
        step();

        // Full decode, chi single-cycle.
        clear_stats();
        decode(1'b0, -1, 0, 1'b0, -1, t0, tdone, extra);
        step();
        chk("lat_done", tdone - t0, 32'd146);
        chk("lat_wr", first_wr - t0, 32'd1);
        chk("lat_addrc", first_add - t0, 32'd2);
        chk("first_round", first_add_round, 32'd23);
        chk("lat_last_col", last_col - t0, 32'd144);
        chk("last_round", last_col_round, 32'd0);
        chk("cnt_wr", cnt_wr, 32'd1);
        chk("cnt_add", cnt_add, 32'd24);
        chk("cnt_chi", cnt_chi, 32'd24);
        chk("cnt_perm", cnt_perm, 32'd24);
        chk("cnt_rot", cnt_rot, 32'd24);
        chk("cnt_col", cnt_col, 32'd24);
        chk("cnt_done", cnt_done, 32'd1);

        // Chi stall of 3 cycles in round 10, start pulsed during round 5.
        clear_stats();
        decode(1'b0, 10, 3, 1'b0, 5, t0, tdone, extra);
        step();
        chk("stall_lat_done", tdone - t0, 32'd149);
        chk("stall_chi_run", max_chi_run, 32'd4);
        chk("stall_cnt_col", cnt_col, 32'd24);
        chk("stall_cnt_done", cnt_done, 32'd1);

        // Start in the Done cycle is ignored; start held into Idle loads next.
        decode(1'b0, -1, 0, 1'b0, -1, t0, tdone, extra);
        start = 1'b1;
        step();
        clear_stats();
        chk("done_start_ignored", {31'd0, busy}, 32'd0);
        step();
        start = 1'b0;
        chk("b2b_load", {31'd0, wr_en}, 32'd1);
        decode(1'b1, -1, 0, 1'b1, -1, t0, tdone, extra);
        step();
        chk("b2b_lat", tdone - t0, 32'(146 + extra));
        chk("b2b_cnt_add", cnt_add, 32'd24);
        chk("b2b_cnt_done", cnt_done, 32'd1);

        // Randomized chi waits and stray start pulses.
        for (int i = 0; i < 3; i++) begin
            clear_stats();
            decode(1'b0, -1, 0, 1'b1, -1, t0, tdone, extra);
            step();
            chk("rand_lat", tdone - t0, 32'(146 + extra));
            chk("rand_cnt_col", cnt_col, 32'd24);
        end

        // Async reset during round 12 InvRotate.
        clear_stats();
        start = 1'b1;
        step();
        start    = 1'b0;
        chi_done = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (invRotate_en && round_idx == 5'd12) found = 1'b1;
            else step();
        end
        chk("reach_r12_rotate", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", dut_vec(), 32'd23);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("async_rst_no_done", cnt_done, 32'd0);
        clear_stats();
        decode(1'b0, -1, 0, 1'b0, -1, t0, tdone, extra);
        step();
        chk("post_rst_lat", tdone - t0, 32'd146);

`ifdef KECCAK_INV_ABORT_EN
        // Abort in round 7 InvRevalute with chi_done high.
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            chi_done = 1'b1;
            if (invRevalute_en && round_idx == 5'd7) found = 1'b1;
            else step();
        end
        chk("reach_r7_chi", {31'd0, found}, 32'd1);
        np       = cnt_perm;
        chi_done = 1'b1;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        chi_done = 1'b0;
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_round", {27'd0, round_idx}, 32'd23);
        step();
        chk("abort_no_perm", cnt_perm, np);
        chk("abort_no_done", cnt_done, 32'd0);

        // Abort in Idle does not block a same-cycle start.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle_start", {31'd0, wr_en}, 32'd1);
        decode(1'b1, -1, 0, 1'b0, -1, t0, tdone, extra);
        step();
        chk("abort_after_lat", tdone - t0, 32'd146);
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
